kb_code_queue: RTL and testbench

KB_CODE_QUEUE -- requirements
Module: kb_code_queue

---
 rtl/kb_code_queue.sv | 135 +++++++++++++
 tb/tb_kb_code_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_code_queue.sv
// +----------------------------------------------------------------------------+
// | kb_code_queue: keyboard scan-code prefix decoder feeding a show-ahead FIFO  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module kb_code_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       ARST,
  input  logic [7:0]                 KBCODE,
  input  logic                       KBSTROBE,
  input  logic                       POP,
  input  logic                       CLR_OVF,
  output logic [7:0]                 CODE,
  output logic                       RELEASE,
  output logic                       VALID,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       OVERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] BYTE_BRK = 8'hF0;
  localparam logic [7:0] BYTE_EXT = 8'hE0;

  typedef enum logic {S_IDLE, S_BRK} state_t;

  state_t            state_q, state_d;
  logic              strobe_q;
  logic [7:0]        last_make_q, last_make_d;
  logic              last_valid_q, last_valid_d;
  logic [8:0]        mem_q [DEPTH];
  logic [8:0]        mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              byte_ev;
  logic              push_req;
  logic              push_rel;
  logic              full;
  logic              empty;
  logic              pop_eff;
  logic              wr_en;

  assign byte_ev = KBSTROBE & ~strobe_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_eff = POP & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign wr_en   = push_req & (~full | pop_eff);

  always_comb begin
    state_d      = state_q;
    last_make_d  = last_make_q;
    last_valid_d = last_valid_q;
    push_req     = 1'b0;
    push_rel     = 1'b0;
    if (byte_ev && KBCODE != BYTE_EXT) begin
      if (state_q == S_IDLE) begin
        if (KBCODE == BYTE_BRK) begin
          state_d = S_BRK;
        end else if (!(last_valid_q && KBCODE == last_make_q)) begin
          push_req     = 1'b1;
          last_make_d  = KBCODE;
          last_valid_d = 1'b1;
        end
      end else if (KBCODE != BYTE_BRK) begin
        push_req = 1'b1;
        push_rel = 1'b1;
        state_d  = S_IDLE;
        if (KBCODE == last_make_q) begin
          last_valid_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = {push_rel, KBCODE};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(wr_en) - CW'(pop_eff);
    ovf_d   = (push_req & full & ~pop_eff) | (ovf_q & ~CLR_OVF);
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q      <= S_IDLE;
      strobe_q     <= 1'b1;
      last_make_q  <= 8'h00;
      last_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      strobe_q     <= KBSTROBE;
      last_make_q  <= last_make_d;
      last_valid_q <= last_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      mem_q        <= mem_d;
    end
  end

  assign CODE     = mem_q[rd_ptr_q][7:0];
  assign RELEASE  = mem_q[rd_ptr_q][8];
  assign VALID    = ~empty;
  assign EMPTY    = empty;
  assign FULL     = full;
  assign COUNT    = count_q;
  assign OVERFLOW = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_kb_code_queue.sv
// +----------------------------------------------------------------------------+
// | tb_kb_code_queue: directed and randomized checks against a queue model      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_kb_code_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic [7:0]    kbcode = 8'h00;
  logic          kbstrobe = 1'b0;
  logic          pop = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [7:0]    code;
  logic          rel;
  logic          valid;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  // Reference model state: entries are {release, code}
  logic [8:0] mq[$];
  logic       m_prev;
  logic       m_brk;
  logic       m_lv;
  logic [7:0] m_lm;
  logic       m_ovf;

  always #5 clk = ~clk;

  kb_code_queue #(.DEPTH(DEPTH)) dut (
    .CLK      (clk),
    .ARST     (arst),
    .KBCODE   (kbcode),
    .KBSTROBE (kbstrobe),
    .POP      (pop),
    .CLR_OVF  (clr_ovf),
    .CODE     (code),
    .RELEASE  (rel),
    .VALID    (valid),
    .EMPTY    (empty),
    .FULL     (full),
    .COUNT    (count),
    .OVERFLOW (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_prev = 1'b1;
    m_brk  = 1'b0;
    m_lv   = 1'b0;
    m_lm   = 8'h00;
    m_ovf  = 1'b0;
  endtask

  task automatic model_update(input logic stb, input logic [7:0] kc, input logic p, input logic clr);
    logic ev, push, prel, popped, was_full, oset;
    ev     = stb & ~m_prev;
    m_prev = stb;
    push   = 1'b0;
    prel   = 1'b0;
    oset   = 1'b0;
    if (ev && kc != 8'hE0) begin
      if (!m_brk) begin
        if (kc == 8'hF0) m_brk = 1'b1;
        else if (!(m_lv && kc == m_lm)) begin
          push = 1'b1;
          m_lm = kc;
          m_lv = 1'b1;
        end
      end else if (kc != 8'hF0) begin
        push  = 1'b1;
        prel  = 1'b1;
        m_brk = 1'b0;
        if (kc == m_lm) m_lv = 1'b0;
      end
    end
    was_full = (mq.size() == DEPTH);
    popped   = p && (mq.size() > 0);
    if (popped) void'(mq.pop_front());
    if (push) begin
      if (!was_full || popped) mq.push_back({prel, kc});
      else oset = 1'b1;
    end
    m_ovf = oset | (m_ovf & ~clr);
  endtask

  task automatic check_all();
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("valid", valid, mq.size() != 0);
    check("full", full, mq.size() == DEPTH);
    check("overflow", ovf, m_ovf);
    if (mq.size() > 0) begin
      check("code", code, mq[0][7:0]);
      check("release", rel, mq[0][8]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update(kbstrobe, kbcode, pop, clr_ovf);
    check_all();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #2;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_valid", valid, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_code", code, 8'h00);
    check("rst_rel", rel, 0);
    @(posedge clk);
    #2;
    arst = 1'b0;
    model_reset();
    step();
  endtask

  task automatic send(input logic [7:0] b);
    kbcode   = b;
    kbstrobe = 1'b1;
    step();
    kbstrobe = 1'b0;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] tbl [8];
    int         pop_pct;
    tbl = '{8'h1C, 8'h1D, 8'hF0, 8'hE0, 8'h75, 8'hF0, 8'h1C, 8'h22};
    model_reset();
    #1;
    do_reset();

    // Press then release of the same key; VALID one cycle after strobe rise
    kbcode = 8'h1C; kbstrobe = 1'b1;
    step();
    check("r35_valid_lat", valid, 1);
    kbstrobe = 1'b0;
    step();
    send(8'hF0);
    send(8'h1C);
    check("r35_count", count, 2);
    check("r35_head0", {rel, code}, {1'b0, 8'h1C});
    pop = 1'b1; step(); pop = 1'b0;
    check("r35_head1", {rel, code}, {1'b1, 8'h1C});

    // Typematic repeats collapse to one make
    do_reset();
    repeat (4) send(8'h1D);
    send(8'hF0);
    send(8'h1D);
    send(8'h1D);
    check("r36_count", count, 3);

    // Extended prefix is invisible
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("r37_count", count, 2);
    check("r37_head", {rel, code}, {1'b0, 8'h75});

    // Overflow on the ninth push, then drain in order
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    check("r38_full", full, 1);
    check("r38_count", count, 8);
    check("r38_ovf", ovf, 1);
    check("r38_head", code, 8'h10);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("r38_ovf_clr", ovf, 0);
    for (int i = 0; i < 8; i++) begin
      check("r38_pop", code, 8'h10 + 8'(i));
      pop = 1'b1; step(); pop = 1'b0;
    end
    check("r38_empty", empty, 1);

    // Push and pop together on a full queue
    do_reset();
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
    kbcode = 8'h20; kbstrobe = 1'b1; pop = 1'b1;
    step();
    check("r39_count", count, 8);
    check("r39_ovf", ovf, 0);
    check("r39_head", code, 8'h31);
    kbstrobe = 1'b0; pop = 1'b0;
    step();
    pop = 1'b1;
    repeat (7) step();
    pop = 1'b0;
    check("r39_tail", {rel, code}, {1'b0, 8'h20});
    pop = 1'b1; step(); step(); pop = 1'b0;
    check("r39_empty_pop", count, 0);

    // Strobe held across reset release; pending break discarded by reset
    kbstrobe = 1'b1;
    do_reset();
    step();
    check("r40_no_spurious", count, 0);
    kbstrobe = 1'b0;
    step();
    send(8'hF0);
    do_reset();
    send(8'h22);
    check("r40_count", count, 1);
    check("r40_entry", {rel, code}, {1'b0, 8'h22});

    // Randomized traffic: low pop rate to provoke overflow, then high
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      pop_pct  = (c < 600) ? 8 : 45;
      kbstrobe = 1'($urandom_range(0, 1));
      kbcode   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : tbl[$urandom_range(0, 7)];
      pop      = ($urandom_range(0, 99) < pop_pct);
      clr_ovf  = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
